// File: rtl/clk_div_multi.sv
// ============================================================================
// clk_div_multi
// ----------------------------------------------------------------------------
// Multi-channel integer clock divider. Every channel divides the single
// reference clock by its own runtime ratio R. The waveform has these
// properties:
//   - the period is R reference cycles;
//   - even R gives 50% duty;
//   - odd R gives (R+1)/2 high cycles and the remainder low;
//   - R==1 passes the reference clock straight through (bypass);
//   - R==0 stops the channel with its output held low.
// A new requested ratio only takes effect at a period boundary (wrap or
// sync) or while the channel is idle/bypassed. This keeps the output free
// of runt pulses.
//
// Ports:
//   clk_ref    in   reference clock, the only clock in the block
//   rst        in   synchronous, active-high reset
//   clk_en     in   [N_CH]          per-channel enable; low clears the channel
//   div_ratio  in   [N_CH*DIV_WD]   requested ratios, channel i at
//                                   [i*DIV_WD +: DIV_WD]
//   sync       in   restarts the period of every enabled, running channel
//   clk_out    out  [N_CH]          divided clocks
//   tick       out  [N_CH]          one-cycle strobe at each clk_out rise
//   ratio_ack  out  [N_CH]          one-cycle strobe when the active ratio
//                                   takes on a new value
// ============================================================================
module clk_div_multi #(
    parameter int N_CH   = 4,
    parameter int DIV_WD = 8
) (
    input  logic                   clk_ref,
    input  logic                   rst,
    input  logic [N_CH-1:0]        clk_en,
    input  logic [N_CH*DIV_WD-1:0] div_ratio,
    input  logic                   sync,
    output logic [N_CH-1:0]        clk_out,
    output logic [N_CH-1:0]        tick,
    output logic [N_CH-1:0]        ratio_ack
);

    // One extra bit of headroom so (R+1) and (cnt+1) cannot overflow when
    // R is the largest representable ratio.
    localparam logic [DIV_WD:0]   ONE_WIDE = {{DIV_WD{1'b0}}, 1'b1};
    localparam logic [DIV_WD-1:0] ONE      = {{(DIV_WD-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        logic [DIV_WD-1:0] req_ratio;
        logic [DIV_WD-1:0] ratio_q;
        logic [DIV_WD-1:0] cnt_q;
        logic              out_q;
        logic              tick_q;
        logic              ack_q;
        logic              byp_q;

        logic [DIV_WD:0]   high_cnt;
        logic [DIV_WD:0]   cnt_inc;
        logic              at_wrap;
        logic              is_idle;
        logic              req_runs;
        logic              req_changed;

        // Per-channel decode of the request and of the current period
        // position. at_wrap is cnt==R-1, written as cnt+1==R so that it
        // never has to subtract from a small R.
        assign req_ratio   = div_ratio[i*DIV_WD +: DIV_WD];
        assign high_cnt    = ({1'b0, ratio_q} + ONE_WIDE) >> 1;
        assign cnt_inc     = {1'b0, cnt_q} + ONE_WIDE;
        assign at_wrap     = (cnt_inc == {1'b0, ratio_q});
        assign is_idle     = ~|ratio_q[DIV_WD-1:1];
        assign req_runs    = |req_ratio[DIV_WD-1:1];
        assign req_changed = (req_ratio != ratio_q);

        // Channel state update. The branch order encodes priority:
        //   1. reset;
        //   2. disable;
        //   3. idle/bypass reload;
        //   4. sync or wrap, which starts a new period and picks up the
        //      requested ratio;
        //   5. plain counting.
        // The bypass select is kept as its own register so that the clock
        // mux below is driven by a flop and not by decode logic.
        always_ff @(posedge clk_ref) begin
            if (rst) begin
                ratio_q <= '0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                ack_q   <= 1'b0;
                byp_q   <= 1'b0;
            end else if (!clk_en[i]) begin
                ratio_q <= '0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                ack_q   <= 1'b0;
                byp_q   <= 1'b0;
            end else if (is_idle) begin
                ratio_q <= req_ratio;
                cnt_q   <= '0;
                out_q   <= req_runs;
                tick_q  <= req_runs;
                ack_q   <= req_changed;
                byp_q   <= (req_ratio == ONE);
            end else if (sync || at_wrap) begin
                ratio_q <= req_ratio;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                tick_q  <= 1'b1;
                ack_q   <= req_changed;
                byp_q   <= (req_ratio == ONE);
            end else begin
                cnt_q   <= cnt_inc[DIV_WD-1:0];
                out_q   <= (cnt_inc < high_cnt);
                tick_q  <= 1'b0;
                ack_q   <= 1'b0;
                byp_q   <= 1'b0;
            end
        end

        // Bypass is the only combinational clock path: the select is a flop
        // output, so it changes only on a reference-clock edge.
        assign clk_out[i]   = byp_q ? clk_ref : out_q;
        assign tick[i]      = tick_q;
        assign ratio_ack[i] = ack_q;

    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// tb_clk_div_multi
// ----------------------------------------------------------------------------
// Self-checking bench for clk_div_multi (N_CH=4, DIV_WD=8, 10 ns clk_ref).
// The sections are:
//   - a directed vector table on channel 0;
//   - hand-written sequences for sync, bypass/stop, disable and reset;
//   - a randomized run compared against a behavioural model.
// The model tracks each channel as {ratio, position within the period} and
// derives the waveform from that position.
// ============================================================================
module tb_clk_div_multi;

    localparam int N_CH   = 4;
    localparam int DIV_WD = 8;

    logic                   clk_ref;
    logic                   rst;
    logic [N_CH-1:0]        clk_en;
    logic [N_CH*DIV_WD-1:0] div_ratio;
    logic                   sync;
    logic [N_CH-1:0]        clk_out;
    logic [N_CH-1:0]        tick;
    logic [N_CH-1:0]        ratio_ack;

    int errors = 0;
    int checks = 0;

    clk_div_multi #(.N_CH(N_CH), .DIV_WD(DIV_WD)) dut (
        .clk_ref   (clk_ref),
        .rst       (rst),
        .clk_en    (clk_en),
        .div_ratio (div_ratio),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .ratio_ack (ratio_ack)
    );

    // 10 ns reference clock
    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    // Behavioural model state: the active ratio, the position inside the
    // current period, and the registered outputs that follow from them.
    int m_ratio [N_CH];
    int m_phase [N_CH];
    bit m_out   [N_CH];
    bit m_tick  [N_CH];
    bit m_ack   [N_CH];

    // Advance the model by one reference cycle, using the inputs that were
    // present at that edge.
    function automatic void model_update(input bit r, input logic [N_CH-1:0] en,
                                         input logic [N_CH*DIV_WD-1:0] d, input bit s);
        for (int c = 0; c < N_CH; c++) begin
            int req;
            req = int'(d[c*DIV_WD +: DIV_WD]);
            if (r || !en[c]) begin
                m_ratio[c] = 0;
                m_phase[c] = 0;
                m_out[c]   = 0;
                m_tick[c]  = 0;
                m_ack[c]   = 0;
            end else if (m_ratio[c] < 2) begin
                m_ack[c]   = (req != m_ratio[c]);
                m_ratio[c] = req;
                m_phase[c] = 0;
                m_out[c]   = (req >= 2);
                m_tick[c]  = (req >= 2);
            end else if (s || m_phase[c] == m_ratio[c] - 1) begin
                m_ack[c]   = (req != m_ratio[c]);
                m_ratio[c] = req;
                m_phase[c] = 0;
                m_out[c]   = 1;
                m_tick[c]  = 1;
            end else begin
                m_phase[c] = m_phase[c] + 1;
                m_out[c]   = (m_phase[c] < (m_ratio[c] + 1) / 2);
                m_tick[c]  = 0;
                m_ack[c]   = 0;
            end
        end
    endfunction

    // Drive one cycle of inputs and let the DUT and the model take the
    // edge. The task returns 1 ns after the edge, so clk_ref is high there.
    task automatic applyStimulus(input bit r, input logic [N_CH-1:0] en,
                                 input logic [N_CH*DIV_WD-1:0] d, input bit s);
        rst       = r;
        clk_en    = en;
        div_ratio = d;
        sync      = s;
        @(posedge clk_ref);
        model_update(r, en, d, s);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                               input logic [N_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs with the model. When sampled just after a rising
    // edge, a bypassed channel (ratio 1) shows the high reference clock.
    task automatic check_model(input string tag);
        logic [N_CH-1:0] e_clk, e_tick, e_ack;
        for (int c = 0; c < N_CH; c++) begin
            e_clk[c]  = (m_ratio[c] == 1) ? 1'b1 : m_out[c];
            e_tick[c] = m_tick[c];
            e_ack[c]  = m_ack[c];
        end
        checkOutput({tag, "_clk"},  clk_out,   e_clk);
        checkOutput({tag, "_tick"}, tick,      e_tick);
        checkOutput({tag, "_ack"},  ratio_ack, e_ack);
    endtask

    // Directed vector table, channel 0 only
    typedef struct {
        bit               rst;
        logic [N_CH-1:0]  en;
        logic [31:0]      ratio;
        logic [N_CH-1:0]  e_clk;
        logic [N_CH-1:0]  e_tick;
        logic [N_CH-1:0]  e_ack;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit r, input bit e0, input int d0,
                                    input bit c, input bit t, input bit a);
        vec_t v;
        v.rst    = r;
        v.en     = {3'b000, e0};
        v.ratio  = {24'd0, 8'(d0)};
        v.e_clk  = {3'b000, c};
        v.e_tick = {3'b000, t};
        v.e_ack  = {3'b000, a};
        vecs.push_back(v);
    endfunction

    logic [N_CH*DIV_WD-1:0] rand_d;
    logic [N_CH-1:0]        rand_en;

    initial begin
        rst       = 1'b1;
        clk_en    = '0;
        div_ratio = '0;
        sync      = 1'b0;

        // ratio 2, then 3, then 7, then 6 with a change to 7 at cnt=2
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(0, 1, 2, 1, 1, 1);
        add_vec(0, 1, 2, 0, 0, 0);
        add_vec(0, 1, 2, 1, 1, 0);
        add_vec(0, 1, 2, 0, 0, 0);
        add_vec(0, 1, 3, 1, 1, 1);
        add_vec(0, 1, 3, 1, 0, 0);
        add_vec(0, 1, 3, 0, 0, 0);
        add_vec(0, 1, 3, 1, 1, 0);
        add_vec(0, 1, 3, 1, 0, 0);
        add_vec(0, 1, 3, 0, 0, 0);
        add_vec(0, 1, 7, 1, 1, 1);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 6, 1, 1, 1);
        add_vec(0, 1, 6, 1, 0, 0);
        add_vec(0, 1, 6, 1, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 1, 1, 1);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 1, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 0, 0, 0);
        add_vec(0, 1, 7, 1, 1, 0);

        $display("[TB] directed vector table, %0d rows", vecs.size());
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].ratio, 1'b0);
            checkOutput($sformatf("vec%0d_clk", k),  clk_out,   vecs[k].e_clk);
            checkOutput($sformatf("vec%0d_tick", k), tick,      vecs[k].e_tick);
            checkOutput($sformatf("vec%0d_ack", k),  ratio_ack, vecs[k].e_ack);
        end

        // Four channels free-running at 2,3,6,7, then a sync pulse
        $display("[TB] sync alignment");
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            applyStimulus(1'b0, 4'hF, {8'd7, 8'd6, 8'd3, 8'd2}, 1'b0);
            check_model("sync_run");
        end
        applyStimulus(1'b0, 4'hF, {8'd7, 8'd6, 8'd3, 8'd2}, 1'b1);
        checkOutput("sync_clk",  clk_out, 4'hF);
        checkOutput("sync_tick", tick,    4'hF);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'hF, {8'd7, 8'd6, 8'd3, 8'd2}, 1'b0);
            check_model("sync_after");
        end

        // Bypass (ratio 1), stop (ratio 0), then ratio 4 from stop
        $display("[TB] bypass and stop");
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'h1, 32'd1, 1'b0);
        checkOutput("byp_hi",   clk_out,   4'h1);
        checkOutput("byp_ack",  ratio_ack, 4'h1);
        checkOutput("byp_tick", tick,      4'h0);
        @(negedge clk_ref);
        #1;
        checkOutput("byp_lo", clk_out, 4'h0);
        applyStimulus(1'b0, 4'h1, 32'd1, 1'b0);
        checkOutput("byp_hold_hi", clk_out, 4'h1);
        applyStimulus(1'b0, 4'h1, 32'd0, 1'b0);
        checkOutput("stop_clk_hi", clk_out,   4'h0);
        checkOutput("stop_ack",    ratio_ack, 4'h1);
        @(negedge clk_ref);
        #1;
        checkOutput("stop_clk_lo", clk_out, 4'h0);
        applyStimulus(1'b0, 4'h1, 32'd0, 1'b0);
        checkOutput("stop_hold", clk_out,   4'h0);
        checkOutput("stop_noack", ratio_ack, 4'h0);
        applyStimulus(1'b0, 4'h1, 32'd4, 1'b0);
        checkOutput("r4_rise", clk_out,   4'h1);
        checkOutput("r4_tick", tick,      4'h1);
        checkOutput("r4_ack",  ratio_ack, 4'h1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'h1, 32'd4, 1'b0);
            check_model("r4_run");
        end

        // Enable dropped mid-period, then re-enabled
        $display("[TB] enable drop");
        applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'd6, 1'b0);
        checkOutput("endrop_clk",  clk_out,   4'h0);
        checkOutput("endrop_tick", tick,      4'h0);
        checkOutput("endrop_ack",  ratio_ack, 4'h0);
        applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
        checkOutput("reen_clk",  clk_out,   4'h1);
        checkOutput("reen_tick", tick,      4'h1);
        checkOutput("reen_ack",  ratio_ack, 4'h1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
            check_model("reen_run");
        end

        // Reset asserted mid-period, then released
        $display("[TB] reset mid-period");
        applyStimulus(1'b1, 4'h1, 32'd6, 1'b0);
        checkOutput("rst_clk",  clk_out,   4'h0);
        checkOutput("rst_tick", tick,      4'h0);
        checkOutput("rst_ack",  ratio_ack, 4'h0);
        applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
        checkOutput("rel_clk",  clk_out,   4'h1);
        checkOutput("rel_tick", tick,      4'h1);
        checkOutput("rel_ack",  ratio_ack, 4'h1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 4'h1, 32'd6, 1'b0);
            check_model("rel_run");
        end

        // Randomized run against the model
        $display("[TB] randomized run");
        rand_en = 4'hF;
        rand_d  = {8'd7, 8'd6, 8'd3, 8'd2};
        for (int n = 0; n < 3000; n++) begin
            bit r_rst, r_sync;
            for (int c = 0; c < N_CH; c++) begin
                int k;
                if ($urandom_range(0, 59) == 0) rand_en[c] = ~rand_en[c];
                if ($urandom_range(0, 24) == 0) begin
                    k = $urandom_range(0, 19);
                    if (k == 0)      rand_d[c*DIV_WD +: DIV_WD] = 8'd0;
                    else if (k == 1) rand_d[c*DIV_WD +: DIV_WD] = 8'd1;
                    else if (k == 2) rand_d[c*DIV_WD +: DIV_WD] = 8'($urandom_range(200, 255));
                    else             rand_d[c*DIV_WD +: DIV_WD] = 8'($urandom_range(2, 12));
                end
            end
            r_rst  = ($urandom_range(0, 399) == 0);
            r_sync = ($urandom_range(0, 39) == 0);
            applyStimulus(r_rst, rand_en, rand_d, r_sync);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, parametrised integer clock divider: N_CH independent divided outputs from one reference clock, each with its own runtime ratio.
- Generalises the single-channel divider with the following features:
  - glitch-free ratio updates, taken only at period boundaries;
  - a defined odd-ratio duty cycle;
  - a per-channel tick strobe, usable as a clock enable;
  - a global sync input that phase-aligns all channels.
- Sits in the clocking/timing subsystem and feeds peripheral enables and slow-clock domains.

Parameters:
- N_CH, 4, number of divider channels.
- DIV_WD, 8, width of each channel's ratio and counter.

Ports:
- clk_ref  in  1  reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  N_CH  per-channel enable; bit i controls channel i.
- div_ratio  in  N_CH*DIV_WD  flattened requested ratios; channel i uses bits [i*DIV_WD +: DIV_WD].
- sync  in  1  one-cycle restart of all enabled, running channels.
- clk_out  out  N_CH  divided clocks.
- tick  out  N_CH  one-cycle pulse at each clk_out rising edge.
- ratio_ack  out  N_CH  one-cycle pulse when a new ratio is loaded into a channel's active register.

Behaviour:
- One clock and one reset: all state is on the rising edge of clk_ref; reset is synchronous and active-high.
- Per-channel state is the active ratio R, the counter cnt and the output register out; tick and ratio_ack are registered.
- H = (R+1)>>1 is the number of high cycles. Compute it at DIV_WD+1 bits so R=2^DIV_WD-1 does not overflow.
- Priority per channel, highest first, evaluated each clock:
  1. rst: R=0, cnt=0, out=0, tick=0, ratio_ack=0.
  2. clk_en[i]=0: R<=0, cnt<=0, out<=0, tick<=0. The channel is cleared, so re-enabling always starts a fresh period.
  3. R<2 (idle or bypass): load R<=div_ratio_i every cycle and set cnt<=0.
     - If div_ratio_i>=2: out<=1, tick<=1 (period starts).
     - Otherwise: out<=0, tick<=0.
  4. sync=1 with R>=2: cnt<=0, R<=div_ratio_i, out<=1, tick<=1. sync overrides wrap and count.
  5. Wrap, cnt==R-1: cnt<=0, R<=div_ratio_i, out<=1, tick<=1.
  6. Otherwise: cnt<=cnt+1, out<=(cnt+1 < H), tick<=0.
- Bypass at R==1: clk_out[i]=clk_ref through a mux whose select is the registered (R==1 && enabled). This is the only combinational clock path. Otherwise clk_out[i]=out.
- R==0: the channel is stopped and clk_out is low.
- ratio_ack[i] pulses one cycle after any cycle in which R is loaded with a value different from its current value. A load of an identical value does not ack.
- A div_ratio change mid-period has no effect until the next wrap, sync, or idle load.
  - The current period completes with the old R.
  - No runt pulse may occur.
- Output waveforms:
  - Even R gives exactly 50% duty.
  - Odd R gives H high and R-H low cycles.
  - Period is R clk_ref cycles.
- Reset mid-operation: all outputs are low the cycle after rst is sampled high.
  - After rst deasserts, the first enabled cycle loads the ratio (rule 3).
  - clk_out rises one cycle after that load.
- Channels are fully independent except for sync.

Test Plan:
- Single channel, rst then clk_en=1, div_ratio=2 → clk_out toggles every cycle (period 20 ns at 10 ns clk_ref); tick on every rising edge; one ratio_ack after the first load.
- div_ratio=3, then 7 → period 3 with high 2 / low 1, then period 7 with high 4 / low 3; tick every 3 and every 7 cycles respectively.
- Ratio change 6→7 written mid-period at cnt=2 → the remaining 6-period completes unchanged, the new period is 7, and ratio_ack pulses exactly once at the boundary.
- N_CH=4 with ratios 2, 3, 6, 7 free-running, then a one-cycle sync pulse → one cycle later all four clk_out are high and all four ticks assert together.
- div_ratio=1 → clk_out equals clk_ref; then div_ratio=0 → clk_out held low; then div_ratio=4 → clk_out rises the cycle after the load.
- clk_en dropped mid-period, and separately rst asserted mid-period → clk_out, tick and ratio_ack low the next cycle; on re-enable/release, a clean period starts with R reloaded.
